// File: rtl/astro_pkg.sv
// Shared constants and state encoding for the tile scheduler and its address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package astro_pkg;

    localparam int WIN_SIDE         = 80;
    localparam int TPL_SIDE         = 16;
    localparam int WORDS_PER_ROW    = 20;
    localparam int WINDOWS_PER_TILE = 4225;

    localparam int TILE_POS_W = 10;
    localparam int WIN_CNT_W  = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_NEXT,
        S_DRAIN,
        S_FIN
    } sched_state_t;

endpackage

// File: rtl/tile_addr_gen.sv
// Translates a handler row/word-column inside the current tile into a pixel-memory word address.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output forced to 0 while en_i is low.
module tile_addr_gen #(
    parameter int IMG_W  = 640,
    parameter int ADDR_W = 18
) (
    input  logic [ADDR_W-1:0] frame_base_i,
    input  logic [9:0]        tile_x_i,
    input  logic [9:0]        tile_y_i,
    input  logic [6:0]        row_i,
    input  logic [6:0]        col_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o
);

    // Words per image row; all arithmetic wraps at ADDR_W, which is the intended truncation.
    localparam logic [ADDR_W-1:0] ROW_WORDS = ADDR_W'(IMG_W / 4);

    // Address = base + absolute row * row pitch + tile word offset + word column.
    always_comb begin
        addr_o = '0;
        if (en_i) begin
            addr_o = frame_base_i
                   + (ADDR_W'(tile_y_i) + ADDR_W'(row_i)) * ROW_WORDS
                   + ADDR_W'(tile_x_i >> 2)
                   + ADDR_W'(col_i);
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// Frame sequencer stepping an 80x80 tile over the image, starting the window handler per tile.
// Latency: wh_en decoded from state; tile_done/frame_done one cycle after handler done / last tile.
// Backpressure: waits on wh_ack to start a tile and on wh_done to close it, bounded by TMO_CYC.
module tile_scheduler
    import astro_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int STRIDE  = 80,
    parameter int ADDR_W  = 18,
    parameter int TMO_CYC = 16384
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     frame_base,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  tile_done,
    output logic [TILE_POS_W-1:0] tile_x,
    output logic [TILE_POS_W-1:0] tile_y,
    output logic [WIN_CNT_W-1:0]  win_count,
    output logic                  err_timeout,
    output logic                  err_count,
    output logic                  wh_en,
    input  logic                  wh_ack,
    input  logic [6:0]            wh_row,
    input  logic [6:0]            wh_col,
    input  logic                  wh_window_ready,
    input  logic                  wh_done,
    output logic [ADDR_W-1:0]     mem_addr
);

    localparam int                    TMO_W    = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [WIN_CNT_W-1:0]  WIN_SAT  = '1;
    localparam logic [WIN_CNT_W-1:0]  WIN_EXP  = WIN_CNT_W'(WINDOWS_PER_TILE);
    localparam logic [TILE_POS_W-1:0] STEP     = TILE_POS_W'(STRIDE);

    sched_state_t          state_q;
    logic [ADDR_W-1:0]     base_q;
    logic [TILE_POS_W-1:0] tile_x_q;
    logic [TILE_POS_W-1:0] tile_y_q;
    logic [WIN_CNT_W-1:0]  win_cnt_q;
    logic [WIN_CNT_W-1:0]  win_cnt_d;
    logic [TMO_W-1:0]      tmo_q;
    logic [TMO_W-1:0]      tmo_d;
    logic                  err_tmo_q;
    logic                  err_cnt_q;
    logic                  abort_pend_q;
    logic                  last_col;
    logic                  last_row;
    logic                  tmo_hit;

    // Tile-grid boundaries, saturating window count and timeout increment.
    always_comb begin
        last_col  = (int'(tile_x_q) + STRIDE) > (IMG_W - WIN_SIDE);
        last_row  = (int'(tile_y_q) + STRIDE) > (IMG_H - WIN_SIDE);
        tmo_hit   = (tmo_q == TMO_LAST);
        tmo_d     = tmo_q + TMO_W'(1);
        win_cnt_d = win_cnt_q;
        if (wh_window_ready && (win_cnt_q != WIN_SAT)) begin
            win_cnt_d = win_cnt_q + WIN_CNT_W'(1);
        end
    end

    // Frame sequencing: tile start handshake, window counting, tile stepping, timeout recovery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            tile_x_q     <= '0;
            tile_y_q     <= '0;
            win_cnt_q    <= '0;
            tmo_q        <= '0;
            err_tmo_q    <= 1'b0;
            err_cnt_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_q      <= S_START;
                        base_q       <= frame_base;
                        tile_x_q     <= '0;
                        tile_y_q     <= '0;
                        win_cnt_q    <= '0;
                        tmo_q        <= '0;
                        err_tmo_q    <= 1'b0;
                        err_cnt_q    <= 1'b0;
                        abort_pend_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (wh_ack && !tmo_hit) begin
                        state_q      <= S_RUN;
                        abort_pend_q <= abort_pend_q | abort;
                        tmo_q        <= tmo_d;
                    end else if (abort && !wh_ack) begin
                        // Handler never accepted this tile, so there is nothing to drain.
                        state_q      <= S_IDLE;
                        abort_pend_q <= 1'b0;
                    end else if (tmo_hit) begin
                        state_q   <= S_DRAIN;
                        err_tmo_q <= 1'b1;
                        tmo_q     <= '0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_RUN: begin
                    win_cnt_q    <= win_cnt_d;
                    abort_pend_q <= abort_pend_q | abort;
                    if (wh_done) begin
                        state_q <= S_NEXT;
                    end else if (tmo_hit) begin
                        state_q   <= S_DRAIN;
                        err_tmo_q <= 1'b1;
                        tmo_q     <= '0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_NEXT: begin
                    err_cnt_q <= err_cnt_q | (win_cnt_q != WIN_EXP);
                    if (abort_pend_q || (last_col && last_row)) begin
                        state_q      <= S_FIN;
                        abort_pend_q <= 1'b0;
                    end else begin
                        if (last_col) begin
                            tile_x_q <= '0;
                            tile_y_q <= tile_y_q + STEP;
                        end else begin
                            tile_x_q <= tile_x_q + STEP;
                        end
                        win_cnt_q <= '0;
                        tmo_q     <= '0;
                        state_q   <= S_START;
                    end
                end
                S_DRAIN: begin
                    if (wh_done || tmo_hit) begin
                        state_q      <= S_FIN;
                        abort_pend_q <= 1'b0;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign wh_en       = (state_q == S_START);
    assign tile_done   = (state_q == S_NEXT);
    assign frame_done  = (state_q == S_FIN);
    assign tile_x      = tile_x_q;
    assign tile_y      = tile_y_q;
    assign win_count   = win_cnt_q;
    assign err_timeout = err_tmo_q;
    assign err_count   = err_cnt_q;

    tile_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .frame_base_i (base_q),
        .tile_x_i     (tile_x_q),
        .tile_y_i     (tile_y_q),
        .row_i        (wh_row),
        .col_i        (wh_col),
        .en_i         (state_q == S_RUN),
        .addr_o       (mem_addr)
    );

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed-sequence bench with randomized handler timing/addresses against a tile-list reference model.
// Latency: checks comb outputs 1 time unit after driving inputs on the falling edge.
// Backpressure: stub handler acks after a random delay and inserts random window gaps.
module tb_tile_scheduler;

    localparam int IMG_W   = 160;
    localparam int IMG_H   = 160;
    localparam int STRIDE  = 80;
    localparam int ADDR_W  = 18;
    localparam int TMO_CYC = 10000;
    localparam int WPT     = 4225;
    localparam int SAT     = 8191;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort, wh_ack, wh_window_ready, wh_done;
    logic [ADDR_W-1:0] frame_base;
    logic [6:0]        wh_row, wh_col;
    logic              busy, frame_done, tile_done, err_timeout, err_count, wh_en;
    logic [9:0]        tile_x, tile_y;
    logic [12:0]       win_count;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    tile_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .STRIDE(STRIDE), .ADDR_W(ADDR_W), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_base(frame_base),
        .busy(busy), .frame_done(frame_done), .tile_done(tile_done),
        .tile_x(tile_x), .tile_y(tile_y), .win_count(win_count),
        .err_timeout(err_timeout), .err_count(err_count), .wh_en(wh_en), .wh_ack(wh_ack),
        .wh_row(wh_row), .wh_col(wh_col), .wh_window_ready(wh_window_ready),
        .wh_done(wh_done), .mem_addr(mem_addr)
    );

    int                checks = 0;
    int                errors = 0;
    int                tile_xs[$];
    int                tile_ys[$];
    int                plan[$];
    logic [ADDR_W-1:0] cur_base;
    bit                exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every legal tile origin in raster order: whole tiles only, stepping by STRIDE.
    function automatic void build_tiles();
        tile_xs.delete();
        tile_ys.delete();
        for (int y = 0; y + 80 <= IMG_H; y += STRIDE)
            for (int x = 0; x + 80 <= IMG_W; x += STRIDE) begin
                tile_xs.push_back(x);
                tile_ys.push_back(y);
            end
    endfunction

    function automatic longint model_addr(input longint base, input int tx, input int ty,
                                          input int row, input int col);
        longint a;
        a = base + longint'(ty + row) * (IMG_W / 4) + tx / 4 + col;
        return a % (longint'(1) << ADDR_W);
    endfunction

    // Drives one tile from START through NEXT; returns at NEXT, 1 unit after the falling edge.
    task automatic run_tile(input int k, input int nwin, input bit do_abort, input bit poke,
                            input bit directed);
        int tx, ty, sent, it, expc;
        bit done_sent, done_with_last, gap;
        tx = tile_xs[k];
        ty = tile_ys[k];
        chk("start_wh_en", wh_en, 1);
        chk("start_busy", busy, 1);
        chk("tile_x", tile_x, tx);
        chk("tile_y", tile_y, ty);
        chk("start_mem_addr", mem_addr, 0);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); #1;
            chk("wh_en_hold", wh_en, 1);
        end
        wh_ack = 1'b1;
        sent = 0; it = 0; done_sent = 0;
        done_with_last = 1'($urandom_range(0, 1));
        while (!done_sent) begin
            @(negedge clk);
            wh_ack = 1'b0; start = 1'b0; abort = 1'b0;
            gap = ($urandom_range(0, 15) == 0);
            wh_window_ready = (sent < nwin) && !gap;
            wh_row = 7'($urandom_range(0, 79));
            wh_col = 7'($urandom_range(0, 19));
            if (directed && sent == 0) begin
                wh_window_ready = 1'b1; wh_row = 7'd3; wh_col = 7'd5;
            end
            if (wh_window_ready) sent++;
            wh_done = (sent == nwin) && (wh_window_ready ? done_with_last : 1'b1);
            if (do_abort && it == 1) abort = 1'b1;
            if (poke && it == 2) begin
                start = 1'b1; frame_base = cur_base ^ 18'h155;
            end
            #1;
            chk("run_wh_en", wh_en, 0);
            chk("mem_addr", mem_addr, model_addr(cur_base, tx, ty, wh_row, wh_col));
            if (directed && it == 0) chk("mem_addr_directed", mem_addr, 245);
            done_sent = wh_done;
            it++;
        end
        @(negedge clk);
        wh_window_ready = 1'b0; wh_done = 1'b0; start = 1'b0; abort = 1'b0;
        #1;
        expc = (nwin > SAT) ? SAT : nwin;
        chk("tile_done", tile_done, 1);
        chk("win_count", win_count, expc);
        chk("next_mem_addr", mem_addr, 0);
        chk("next_busy", busy, 1);
        if (expc != WPT) exp_err = 1'b1;
    endtask

    // Runs a whole frame with the window counts in plan; abort_tile < 0 means no abort.
    task automatic run_frame(input logic [ADDR_W-1:0] base, input int abort_tile, input bit poke);
        bit last;
        @(negedge clk);
        start = 1'b1; frame_base = base; cur_base = base; exp_err = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("err_timeout_clr", err_timeout, 0);
        chk("err_count_clr", err_count, 0);
        for (int k = 0; k < tile_xs.size(); k++) begin
            run_tile(k, plan[k], k == abort_tile, poke && k == 0, base == 18'd100 && k == 1);
            last = (k == tile_xs.size() - 1) || (k == abort_tile);
            @(negedge clk); #1;
            chk("err_count", err_count, exp_err);
            chk("tile_done_pulse", tile_done, 0);
            if (last) begin
                chk("frame_done", frame_done, 1);
                @(negedge clk); #1;
                chk("frame_done_pulse", frame_done, 0);
                chk("idle_busy", busy, 0);
                repeat (3) begin
                    @(negedge clk); #1;
                    chk("no_tile_after_end", wh_en, 0);
                end
                break;
            end else begin
                chk("frame_done_early", frame_done, 0);
            end
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; wh_ack = 1'b0; wh_window_ready = 1'b0;
        wh_done = 1'b0; wh_row = '0; wh_col = '0; frame_base = '0; cur_base = '0; exp_err = 1'b0;
        build_tiles();
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_wh_en", wh_en, 0);
        chk("rst_tile_xy", {tile_x, tile_y}, 0);
        chk("rst_win_count", win_count, 0);
        chk("rst_errs", {err_timeout, err_count}, 0);
        chk("rst_pulses", {tile_done, frame_done}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // start together with abort in IDLE is ignored
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0; #1;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_wh_en", wh_en, 0);

        // clean frame, base near the top of memory so addresses wrap
        plan = '{WPT, WPT, WPT, WPT};
        run_frame(18'h3FFC0, -1, 1'b0);

        // short count, saturation, empty tile; start pulse while busy is ignored
        plan = '{WPT - 1, 8200, 0, 5};
        run_frame(18'd100, -1, 1'b1);

        // handler accepts but never finishes: timeout then drain
        @(negedge clk); start = 1'b1; frame_base = '0;
        @(negedge clk); start = 1'b0; #1;
        chk("tmo_wh_en", wh_en, 1);
        wh_ack = 1'b1;
        n = 0;
        while (n < 3 * TMO_CYC) begin
            @(negedge clk); wh_ack = 1'b0; n++; #1;
            if (err_timeout) break;
        end
        chk("tmo_cycle", n, TMO_CYC);
        chk("tmo_busy", busy, 1);
        while (n < 4 * TMO_CYC) begin
            @(negedge clk); n++; #1;
            if (frame_done) break;
        end
        chk("tmo_frame_done_cycle", n, 2 * TMO_CYC);
        @(negedge clk); #1;
        chk("tmo_idle_busy", busy, 0);
        chk("tmo_sticky", err_timeout, 1);

        // abort during RUN of the third tile: it finishes, frame ends, fourth never starts
        plan = '{2, 2, 2, 2};
        run_frame(18'd4000, 2, 1'b0);

        // abort in START before the handler acks
        @(negedge clk); start = 1'b1; frame_base = 18'd5;
        @(negedge clk); start = 1'b0; abort = 1'b1; #1;
        chk("abort_start_wh_en", wh_en, 1);
        @(negedge clk); abort = 1'b0; #1;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_wh_en_off", wh_en, 0);
        repeat (4) begin
            @(negedge clk); #1;
            chk("abort_start_no_frame_done", frame_done, 0);
        end

        // asynchronous reset in the middle of the second tile
        @(negedge clk); start = 1'b1; frame_base = 18'd777; cur_base = 18'd777;
        @(negedge clk); start = 1'b0; #1;
        run_tile(0, 2, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("rst_pre_tile_x", tile_x, 80);
        wh_ack = 1'b1;
        @(negedge clk); wh_ack = 1'b0; wh_window_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        @(negedge clk); wh_window_ready = 1'b0; #1;
        chk("rst_pre_win_count", win_count, 3);
        chk("rst_pre_err_count", err_count, 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tile_xy", {tile_x, tile_y}, 0);
        chk("mid_rst_win_count", win_count, 0);
        chk("mid_rst_errs", {err_timeout, err_count}, 0);
        chk("mid_rst_pulses", {tile_done, frame_done, wh_en}, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
